// File: rtl/uart_echo_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_buffer_pkg
// Purpose  : Shared types and constants for the UART echo buffer: tx FSM
//            state encoding, busy timeout, error counter width and a
//            saturating increment helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_echo_buffer_pkg;

  // Transmit handshake states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_state_e;

  // Cycles to wait for uart_tx to raise busy before assuming the byte went out
  localparam int BUSY_TIMEOUT = 4;
  localparam int BUSY_TMR_W   = $clog2(BUSY_TIMEOUT);

  // Width of the rx error statistics counter
  localparam int ERR_CNT_W    = 8;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_echo_buffer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_buffer_sync_fifo
// Purpose  : DEPTH x 8 synchronous FIFO with first-word-fall-through head.
//            A write while full is only taken when a read happens on the
//            same edge, so the occupancy stays at DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module uart_echo_buffer_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  // Storage is not reset: pointers alone define which entries are valid
  logic [7:0]      mem_q [DEPTH];

  // Pointers carry one extra wrap bit so wr-rd gives 0..DEPTH directly
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            wr_fire;
  logic            rd_fire;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_fire = rd_en & ~empty;
  assign wr_fire = wr_en & (~full | rd_fire);
  assign rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];

  // Next-pointer computation; pointers wrap naturally modulo 2*DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry write on an accepted push
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_echo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_buffer
// Purpose  : Buffered loopback between uart_rx and uart_tx. Good received
//            bytes are queued and replayed through the tx_start/tx_busy
//            handshake; tracks FIFO level, sticky overflow and a saturating
//            rx error count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_echo_buffer
  import uart_echo_buffer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [7:0]           rx_data,
  input  logic                 rx_done,
  input  logic                 rx_error,
  input  logic                 tx_busy,
  input  logic                 clr_status,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  output logic [ADDR_W:0]      fifo_count,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic                  push_req;
  logic                  launch;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            fifo_head;

  logic                  overflow_q, overflow_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  tx_state_e             state_q;
  logic [7:0]            tx_data_q;
  logic                  tx_start_q;
  logic [BUSY_TMR_W-1:0] timer_q;

  // A byte flagged with an error is never queued
  assign push_req = rx_done & ~rx_error;

  // Launch doubles as the FIFO pop: only from IDLE with data and tx free
  assign launch   = (state_q == ST_IDLE) & ~fifo_empty & ~tx_busy;

  uart_echo_buffer_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (push_req),
    .wr_data (rx_data),
    .rd_en   (launch),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Status bookkeeping; a clear request overrides any same-cycle event
  always_comb begin
    overflow_d = overflow_q;
    err_cnt_d  = err_cnt_q;
    if (clr_status) begin
      overflow_d = 1'b0;
      err_cnt_d  = '0;
    end else begin
      if (push_req && fifo_full && !launch) overflow_d = 1'b1;
      if (rx_error)                         err_cnt_d  = sat_inc(err_cnt_q);
    end
  end

  // Status registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Transmit FSM with registered tx_data/tx_start; WAIT_BUSY times out so a
  // uart_tx that never acknowledges cannot stall the queue
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      timer_q    <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            tx_data_q  <= fifo_head;
            tx_start_q <= 1'b1;
            timer_q    <= '0;
            state_q    <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (timer_q == BUSY_TMR_W'(BUSY_TIMEOUT - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q + BUSY_TMR_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign overflow = overflow_q;
  assign err_cnt  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_echo_buffer
// Purpose  : Scoreboard bench for uart_echo_buffer with a simple uart_tx
//            busy model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_echo_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk        = 1'b0;
  logic              rstn       = 1'b0;
  logic [7:0]        rx_data    = 8'h00;
  logic              rx_done    = 1'b0;
  logic              rx_error   = 1'b0;
  logic              clr_status = 1'b0;
  logic              model_busy = 1'b0;
  logic              tx_busy;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic [ADDR_W:0]   fifo_count;
  logic              overflow;
  logic [7:0]        err_cnt;

  int                checks       = 0;
  int                failures     = 0;
  int                cycle        = 0;
  int                tx_start_cnt = 0;
  int                start_cycles[$];
  logic [7:0]        exp_q[$];
  logic [7:0]        last_launch  = 8'h00;
  bit                force_busy   = 1'b0;
  bit                no_busy      = 1'b0;
  int                busy_len     = 3;

  // uart_tx shares rstn, so its busy drops as soon as reset asserts
  assign tx_busy = model_busy & rstn;

  uart_echo_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .rx_error   (rx_error),
    .tx_busy    (tx_busy),
    .clr_status (clr_status),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive rx/clr inputs just after the active edge
  task automatic step_rx(input logic [7:0] d, input bit done, input bit err, input bit clr);
    @(posedge clk);
    #1;
    rx_data    = d;
    rx_done    = done;
    rx_error   = err;
    clr_status = clr;
  endtask

  // Wait until the queue has drained and tx is quiet, bounded
  task automatic wait_idle();
    int n     = 0;
    int quiet = 0;
    while (quiet < 8 && n < 3000) begin
      @(negedge clk);
      n++;
      if (fifo_count == '0 && !tx_busy && !tx_start) quiet++;
      else quiet = 0;
    end
    if (quiet < 8) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // uart_tx model: busy for busy_len cycles from tx_start, or forced high/low
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rstn) begin
        cnt        = 0;
        model_busy = 1'b0;
      end else if (force_busy) begin
        model_busy = 1'b1;
      end else if (no_busy) begin
        model_busy = 1'b0;
      end else begin
        if (tx_start) cnt = busy_len;
        if (cnt > 0) begin
          model_busy = 1'b1;
          cnt--;
        end else begin
          model_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: each tx_start pops the scoreboard; data must hold until busy falls
  initial begin
    bit         prev_busy;
    logic [7:0] e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_busy = 1'b0;
      end else begin
        if (tx_start === 1'b1) begin
          tx_start_cnt++;
          start_cycles.push_back(cycle);
          if (exp_q.size() == 0) begin
            chk("unexpected_tx_start", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data_at_start", 32'(tx_data), 32'(e));
            last_launch = e;
          end
        end
        if (prev_busy && !tx_busy) chk("tx_data_held", 32'(tx_data), 32'(last_launch));
        prev_busy = tx_busy;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;

    // Reset values
    @(negedge clk);
    chk("rst_tx_data",    32'(tx_data),    32'h00);
    chk("rst_tx_start",   32'(tx_start),   32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow",   32'(overflow),   32'd0);
    chk("rst_err_cnt",    32'(err_cnt),    32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // 1. Single byte: tx_start two cycles after rx_done
    step_rx(8'h5A, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h5A);
    step_rx(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_count_k1",    32'(fifo_count), 32'd1);
    chk("t1_start_k1",    32'(tx_start),   32'd0);
    @(negedge clk);
    chk("t1_start_k2",    32'(tx_start),   32'd1);
    chk("t1_data_k2",     32'(tx_data),    32'h5A);
    chk("t1_count_k2",    32'(fifo_count), 32'd0);
    wait_idle();

    // 2. Burst of 20 while tx is busy: 16 kept, overflow set
    @(posedge clk);
    #1 force_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step_rx(8'(i), 1'b1, 1'b0, 1'b0);
      if (i < DEPTH) exp_q.push_back(8'(i));
    end
    step_rx(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_count_full",  32'(fifo_count), 32'd16);
    chk("t2_overflow",    32'(overflow),   32'd1);
    @(posedge clk);
    #1 force_busy = 1'b0;
    wait_idle();
    chk("t2_ovf_sticky",  32'(overflow),   32'd1);
    step_rx(8'h00, 1'b0, 1'b0, 1'b1);
    step_rx(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_ovf_cleared", 32'(overflow),   32'd0);

    // 3. Errors: bad byte discarded, counter saturates, clear wins
    step_rx(8'hFF, 1'b1, 1'b1, 1'b0);
    step_rx(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_err_count",   32'(fifo_count), 32'd0);
    chk("t3_err_one",     32'(err_cnt),    32'd1);
    for (int i = 0; i < 300; i++) step_rx(8'h00, 1'b0, 1'b1, 1'b0);
    step_rx(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_err_sat",     32'(err_cnt),    32'd255);
    chk("t3_err_nothing_queued", 32'(fifo_count), 32'd0);
    step_rx(8'h00, 1'b0, 1'b1, 1'b1);
    step_rx(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_clr_wins",    32'(err_cnt),    32'd0);
    chk("t3_clr_ovf",     32'(overflow),   32'd0);
    step_rx(8'h00, 1'b0, 1'b1, 1'b0);
    step_rx(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_err_after_clr", 32'(err_cnt),  32'd1);

    // 4. Full FIFO, push on the same edge as a pop
    @(posedge clk);
    #1 force_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step_rx(8'hA0 + 8'(i), 1'b1, 1'b0, 1'b0);
      exp_q.push_back(8'hA0 + 8'(i));
    end
    @(posedge clk);
    #1;
    force_busy = 1'b0;
    rx_data    = 8'hB0;
    rx_done    = 1'b1;
    rx_error   = 1'b0;
    exp_q.push_back(8'hB0);
    @(negedge clk);
    chk("t4_count_before", 32'(fifo_count), 32'd16);
    step_rx(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_count_after",  32'(fifo_count), 32'd16);
    chk("t4_no_overflow",  32'(overflow),   32'd0);
    wait_idle();

    // 5. Busy never rises: timeout returns to IDLE, next byte launches
    no_busy = 1'b1;
    start_cycles.delete();
    step_rx(8'h11, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h11);
    step_rx(8'h22, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h22);
    step_rx(8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40 && start_cycles.size() < 2; i++) @(negedge clk);
    chk("t5_two_launches", 32'(start_cycles.size()), 32'd2);
    if (start_cycles.size() >= 2)
      chk("t5_launch_gap", 32'(start_cycles[1] - start_cycles[0]), 32'd5);
    wait_idle();
    no_busy = 1'b0;

    // 6. Reset while in WAIT_DONE with 5 bytes queued
    busy_len = 20;
    @(posedge clk);
    #1 force_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_rx(8'h31 + 8'(i), 1'b1, 1'b0, 1'b0);
      exp_q.push_back(8'h31 + 8'(i));
    end
    step_rx(8'h00, 1'b0, 1'b0, 1'b0);
    force_busy = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_queued",       32'(fifo_count), 32'd5);
    chk("t6_err_before",   32'(err_cnt),    32'd1);
    rstn = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_tx_data",  32'(tx_data),    32'h00);
    chk("t6_rst_tx_start", 32'(tx_start),   32'd0);
    chk("t6_rst_count",    32'(fifo_count), 32'd0);
    chk("t6_rst_overflow", 32'(overflow),   32'd0);
    chk("t6_rst_err_cnt",  32'(err_cnt),    32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    busy_len = 3;
    snap = tx_start_cnt;
    repeat (10) @(negedge clk);
    chk("t6_no_start_after_rst", 32'(tx_start_cnt - snap), 32'd0);
    step_rx(8'h77, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h77);
    step_rx(8'h00, 1'b0, 1'b0, 1'b0);
    wait_idle();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
